// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC/nPC pair for delayed branching, IF/ID register,
// stall / nullify / halt handling.
// Optional macro FETCH_PERF_EN adds saturating fetch_count / stall_count outputs.
module fetch_stage #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               nullify,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
`ifdef FETCH_PERF_EN
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_count,
`endif
  output logic               halted
);

  localparam logic [ADDR_W-1:0] PC_RST     = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  npc_q, npc_d;
  logic [ADDR_W-1:0]  npc_next;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;

  // Memory is combinational, so the PC register drives the address directly
  assign imem_addr = pc_q;

  // Next nPC: word-aligned branch target or sequential (wraps modulo 2^ADDR_W)
  assign npc_next = branch_taken ? (branch_target & ALIGN_MASK) : npc_q + PC_STEP;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= PC_RST;
      npc_q    <= PC_RST + PC_STEP;
      instr_q  <= '0;
      ifpc_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Next-state and datapath update; priority halt_req > nullify > stall > normal
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        instr_d = '0;
        ifpc_d  = '0;
        valid_d = 1'b0;
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
          instr_d = '0;
          ifpc_d  = '0;
          valid_d = 1'b0;
        end else begin
          if (!stall) begin
            pc_d  = npc_q;
            npc_d = npc_next;
          end
          if (nullify) begin
            instr_d = '0;
            ifpc_d  = '0;
            valid_d = 1'b0;
          end else if (!stall) begin
            instr_d = imem_instr;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
          end
        end
      end
      HALT: begin
        instr_d = '0;
        ifpc_d  = '0;
        valid_d = 1'b0;
      end
      default: state_d = BOOT;
    endcase
    halted_d = (state_d == HALT);
  end

  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign halted      = halted_q;

`ifdef FETCH_PERF_EN
  logic        fetch_inc;
  logic        stall_inc;
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  // Events counted: a valid IF/ID load, and a stalled (non-halting) RUN edge
  assign fetch_inc = (state_q == RUN) && !halt_req && !nullify && !stall;
  assign stall_inc = (state_q == RUN) && !halt_req && stall;

  // Saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_inc && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (stall_inc && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        nullify;
  logic        halt_req;
  logic [31:0] if_id_instr;
  logic [7:0]  if_id_pc;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory word is a tagged copy of its own address, never zero
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {16'hC0DE, 8'h5A, a};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .nullify       (nullify),
    .halt_req      (halt_req),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
`ifdef FETCH_PERF_EN
    .fetch_count   (fetch_count),
    .stall_count   (stall_count),
`endif
    .halted        (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Check the IF/ID register and the current fetch address
  task automatic chk_if(input string tag, input logic [7:0] p, input logic v, input logic [7:0] ia);
    check({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    check({tag, ".pc"},    32'(if_id_pc),    v ? 32'(p) : 32'h0);
    check({tag, ".instr"}, if_id_instr,      v ? mem_word(p) : 32'h0);
    check({tag, ".addr"},  32'(imem_addr),   32'(ia));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    nullify = 1'b0; halt_req = 1'b0;
    #3;
    chk_if("rst", 8'h00, 1'b0, 8'h00);
    check("rst.halted", 32'(halted), 32'h0);
    #9 reset = 1'b0;                       // released at t=12, next edge t=15

    step(); chk_if("boot", 8'h00, 1'b0, 8'h00);
    step(); chk_if("seq0", 8'h00, 1'b1, 8'h04);
    step(); chk_if("seq1", 8'h04, 1'b1, 8'h08);
    step(); chk_if("seq2", 8'h08, 1'b1, 8'h0C);
    step(); chk_if("seq3", 8'h0C, 1'b1, 8'h10);

    // Delayed branch to misaligned target 0x41 issued at PC=0x10
    branch_taken = 1'b1; branch_target = 8'h41;
    step(); chk_if("br0", 8'h10, 1'b1, 8'h14);
    branch_taken = 1'b0;
    step(); chk_if("br_slot", 8'h14, 1'b1, 8'h40);
    step(); chk_if("br_tgt", 8'h40, 1'b1, 8'h44);

    // Steer to PC=0x20 for the stall window
    branch_taken = 1'b1; branch_target = 8'h20;
    step(); chk_if("to20a", 8'h44, 1'b1, 8'h48);
    branch_taken = 1'b0;
    step(); chk_if("to20b", 8'h48, 1'b1, 8'h20);
`ifdef FETCH_PERF_EN
    check("perf.fetch9", 32'(fetch_count), 32'd9);
    check("perf.stall0", 32'(stall_count), 32'd0);
`endif

    // Stall three edges; a branch request during stall must be ignored
    stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h80;
    for (int i = 0; i < 3; i++) begin
      step(); chk_if($sformatf("stall%0d", i), 8'h48, 1'b1, 8'h20);
    end
`ifdef FETCH_PERF_EN
    check("perf.stall3", 32'(stall_count), 32'd3);
    check("perf.fetch_hold", 32'(fetch_count), 32'd9);
`endif
    stall = 1'b0; branch_taken = 1'b0;
    step(); chk_if("resume0", 8'h20, 1'b1, 8'h24);
    step(); chk_if("resume1", 8'h24, 1'b1, 8'h28);

    // Nullify squashes 0x28, PC still advances
    nullify = 1'b1;
    step(); chk_if("null", 8'h00, 1'b0, 8'h2C);
    nullify = 1'b0;
    step(); chk_if("null_next", 8'h2C, 1'b1, 8'h30);

    // Nullify together with stall: bubble, PC held
    nullify = 1'b1; stall = 1'b1;
    step(); chk_if("null_stall", 8'h00, 1'b0, 8'h30);
    nullify = 1'b0; stall = 1'b0;
    step(); chk_if("null_stall_next", 8'h30, 1'b1, 8'h34);

    // Wrap-around: branch to 0xFB (aligned to 0xF8) then run sequentially
    branch_taken = 1'b1; branch_target = 8'hFB;
    step(); chk_if("wr_br", 8'h34, 1'b1, 8'h38);
    branch_taken = 1'b0;
    step(); chk_if("wr_slot", 8'h38, 1'b1, 8'hF8);
    step(); chk_if("wr_f8", 8'hF8, 1'b1, 8'hFC);
    step(); chk_if("wr_fc", 8'hFC, 1'b1, 8'h00);
    step(); chk_if("wr_00", 8'h00, 1'b1, 8'h04);
    step(); chk_if("wr_04", 8'h04, 1'b1, 8'h08);

    // Halt: PC frozen at 0x08, bubble, halted high
    halt_req = 1'b1;
    step(); chk_if("halt0", 8'h00, 1'b0, 8'h08);
    check("halt0.halted", 32'(halted), 32'h1);
    halt_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(); chk_if($sformatf("halt_hold%0d", i), 8'h00, 1'b0, 8'h08);
      check($sformatf("halt_hold%0d.halted", i), 32'(halted), 32'h1);
    end

    // Asynchronous reset in the middle of HALT
    #2 reset = 1'b1;
    #1;
    chk_if("rst_mid", 8'h00, 1'b0, 8'h00);
    check("rst_mid.halted", 32'(halted), 32'h0);
`ifdef FETCH_PERF_EN
    check("rst_mid.fetch", 32'(fetch_count), 32'd0);
`endif
    #2 reset = 1'b0;
    step(); chk_if("reboot", 8'h00, 1'b0, 8'h00);
    step(); chk_if("reboot_seq0", 8'h00, 1'b1, 8'h04);
    check("reboot.halted", 32'(halted), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the PA-RISC pipeline. Sits directly upstream of instruction_memory and drives its 8-bit byte address.
- Holds the PC/nPC pair used for PA-RISC delayed branching.
- Captures the 32-bit big-endian word returned by the memory into the IF/ID pipeline register consumed by decode.
- Handles stall, nullify (flush) and halt.

Parameters:
- ADDR_W, 8, byte-address width; matches the 256-byte instruction memory.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value after reset. Must be a multiple of 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  ADDR_W  address to instruction_memory; combinational copy of PC.
- imem_instr  input  INSTR_W  instruction word returned for imem_addr, same cycle.
- stall  input  1  hazard stall from decode; freezes PC, nPC and IF/ID.
- branch_taken  input  1  taken branch resolved in decode.
- branch_target  input  ADDR_W  branch destination byte address.
- nullify  input  1  squash the instruction currently in IF/ID (PA-RISC ,n completer).
- halt_req  input  1  stop fetching.
- if_id_instr  output  INSTR_W  latched instruction.
- if_id_pc  output  ADDR_W  PC of the latched instruction.
- if_id_valid  output  1  latched instruction is real (not a bubble).
- halted  output  1  block is in HALT.

Behaviour:
- Reset (async, any time, including mid-operation):
  - PC=RESET_PC, nPC=RESET_PC+4, state=BOOT.
  - if_id_instr=0, if_id_pc=0, if_id_valid=0, halted=0, counters=0.
- imem_addr = PC, combinational. Instruction memory is combinational, so fetch latency is zero cycles to imem_instr and one cycle to the IF/ID outputs.
- States:
  - BOOT: one cycle. PC/nPC hold; IF/ID loads a bubble (instr=0, valid=0). Next state is RUN unconditionally.
  - RUN: normal fetch. On halt_req=1, next state is HALT and IF/ID loads a bubble; the PC does not advance on that edge.
  - HALT: PC, nPC and IF/ID hold a bubble; halted=1. Only reset exits HALT.
- RUN edge priority (highest first): halt_req, nullify, stall, normal.
  - Normal (stall=0):
    - if_id_instr<=imem_instr, if_id_pc<=PC, if_id_valid<=1.
    - PC<=nPC.
    - nPC <= branch_taken ? {branch_target[ADDR_W-1:2],2'b00} : nPC+4.
    - The instruction at the old nPC is the delay slot and is always fetched.
  - stall=1: PC, nPC and IF/ID hold. branch_taken is ignored; decode holds its request until stall drops.
  - nullify=1:
    - IF/ID loads a bubble (instr=0, valid=0, pc=0) regardless of stall.
    - PC/nPC update as if nullify were 0, i.e. they still obey stall and branch_taken.
    - nullify with stall=0 squashes the slot and fetch continues.
- Arithmetic:
  - All PC math is modulo 2^ADDR_W; 0xFC+4 wraps to 0x00, with no flag.
  - branch_target bits [1:0] are forced to 0, so misaligned targets are silently word-aligned.
- A branch whose target equals nPC is legal and behaves as sequential fetch.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds outputs fetch_count (16 bits) and stall_count (16 bits).
  - fetch_count increments on every RUN edge that loads if_id_valid=1.
  - stall_count increments on every RUN edge with stall=1 and halt_req=0.
  - Both saturate at 0xFFFF and are cleared by reset.
- When undefined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then release with stall=0, memory preloaded at 0x00/0x04/0x08 -> cycle 1 if_id_valid=0 (BOOT); edges 2,3,4 give if_id_pc=0x00,0x04,0x08 with matching if_id_instr; imem_addr sequence 0x00,0x04,0x08,0x0C.
- At PC=0x10, assert branch_taken with branch_target=0x41 for one edge -> next if_id_pc values are 0x14 (delay slot), then 0x40; imem_addr never equals 0x41.
- Hold stall=1 for 3 edges at PC=0x20 -> PC, nPC and IF/ID unchanged for 3 cycles; stall_count +3 when FETCH_PERF_EN is defined; fetch resumes at 0x20 with no skipped or duplicated instruction.
- nullify=1 for one edge with if_id_pc=0x24 -> if_id_valid=0 and if_id_instr=0 next cycle; following edge if_id_pc=0x2C (PC still advanced).
- Run from PC=0xF8 sequentially -> if_id_pc 0xF8, 0xFC, 0x00, 0x04 (wrap).
- halt_req=1 in RUN, then assert reset mid-HALT -> halted=1, imem_addr frozen, if_id_valid=0; reset returns PC=0x00, halted=0 and BOOT.
